// File: rtl/riscv_mem_arbiter.sv
// Shares one single-outstanding memory bus between the core's fetch and data ports.
// Data wins by default; a starvation counter forces fetch grants and a timeout turns a lost ack into an error.
module riscv_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        i_rd_i,
  input  logic [31:0] i_pc_i,
  output logic        i_accept_o,
  output logic        i_valid_o,
  output logic [31:0] i_inst_o,
  output logic        i_error_o,
  input  logic        d_rd_i,
  input  logic [3:0]  d_wr_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_data_wr_i,
  input  logic [10:0] d_req_tag_i,
  output logic        d_accept_o,
  output logic        d_ack_o,
  output logic [31:0] d_data_rd_o,
  output logic        d_error_o,
  output logic [10:0] d_resp_tag_o,
  output logic        mem_req_o,
  input  logic        mem_accept_i,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_rd_o,
  output logic [3:0]  mem_wr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_error_i,
  output logic        busy_o
);
  localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX   = SW'(STARVE_LIMIT);
  localparam logic [7:0]    TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_I_ADDR, ST_I_WAIT, ST_D_ADDR, ST_D_WAIT} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [7:0]    timeout_q, timeout_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]    wr_q, wr_d;
  logic          rd_q, rd_d;
  logic [10:0]   tag_q, tag_d;
  logic          i_valid_q, i_valid_d, i_err_q, i_err_d;
  logic [31:0]   i_inst_q, i_inst_d;
  logic          d_ack_q, d_ack_d, d_err_q, d_err_d;
  logic [31:0]   d_data_q, d_data_d;
  logic [10:0]   d_tag_q, d_tag_d;
  logic          i_pend, d_pend, grant_i, grant_d;

  // Requesters hold their request until the accept pulse; mem_req_o is held with
  // stable fields until mem_accept_i, and a transfer happens when both are high.
  assign i_pend = i_rd_i;
  assign d_pend = d_rd_i | (|d_wr_i);

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_q == ST_IDLE && !rst_i) begin
      if (i_pend && (!d_pend || starve_q == STARVE_MAX)) grant_i = 1'b1;
      else if (d_pend)                                   grant_d = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    timeout_d = timeout_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    tag_d     = tag_q;
    i_valid_d = 1'b0;
    i_err_d   = 1'b0;
    i_inst_d  = i_inst_q;
    d_ack_d   = 1'b0;
    d_err_d   = 1'b0;
    d_data_d  = d_data_q;
    d_tag_d   = d_tag_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_i) begin
          state_d  = ST_I_ADDR;
          addr_d   = i_pc_i;
          wdata_d  = 32'h0;
          rd_d     = 1'b1;
          wr_d     = 4'h0;
          starve_d = '0;
        end else if (grant_d) begin
          state_d = ST_D_ADDR;
          addr_d  = d_addr_i;
          wdata_d = d_data_wr_i;
          rd_d    = d_rd_i;
          wr_d    = d_wr_i;
          tag_d   = d_req_tag_i;
          if (i_pend && starve_q != STARVE_MAX) starve_d = starve_q + 1'b1;
        end
      end
      ST_I_ADDR, ST_D_ADDR: begin
        if (mem_accept_i) begin
          state_d   = (state_q == ST_I_ADDR) ? ST_I_WAIT : ST_D_WAIT;
          timeout_d = 8'h0;
        end
      end
      ST_I_WAIT, ST_D_WAIT: begin
        if (!mem_ack_i) timeout_d = timeout_q + 8'd1;
        // An ack arriving in the timeout cycle still completes normally.
        if (mem_ack_i || timeout_q == TIMEOUT_LAST) begin
          state_d = ST_IDLE;
          if (state_q == ST_D_WAIT) begin
            d_ack_d  = 1'b1;
            d_err_d  = mem_ack_i ? mem_error_i : 1'b1;
            d_data_d = mem_ack_i ? mem_rdata_i : 32'h0;
            d_tag_d  = tag_q;
          end else begin
            i_valid_d = 1'b1;
            i_err_d   = mem_ack_i ? mem_error_i : 1'b1;
            i_inst_d  = mem_ack_i ? mem_rdata_i : 32'h0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      starve_q  <= '0;
      timeout_q <= 8'h0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      wr_q      <= 4'h0;
      rd_q      <= 1'b0;
      tag_q     <= 11'h0;
      i_valid_q <= 1'b0;
      i_err_q   <= 1'b0;
      i_inst_q  <= 32'h0;
      d_ack_q   <= 1'b0;
      d_err_q   <= 1'b0;
      d_data_q  <= 32'h0;
      d_tag_q   <= 11'h0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      timeout_q <= timeout_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      tag_q     <= tag_d;
      i_valid_q <= i_valid_d;
      i_err_q   <= i_err_d;
      i_inst_q  <= i_inst_d;
      d_ack_q   <= d_ack_d;
      d_err_q   <= d_err_d;
      d_data_q  <= d_data_d;
      d_tag_q   <= d_tag_d;
    end
  end

  assign i_accept_o   = grant_i;
  assign d_accept_o   = grant_d;
  assign i_valid_o    = i_valid_q;
  assign i_inst_o     = i_inst_q;
  assign i_error_o    = i_err_q;
  assign d_ack_o      = d_ack_q;
  assign d_data_rd_o  = d_data_q;
  assign d_error_o    = d_err_q;
  assign d_resp_tag_o = d_tag_q;
  assign mem_req_o    = (state_q == ST_I_ADDR) || (state_q == ST_D_ADDR);
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;
  assign mem_rd_o     = mem_req_o & rd_q;
  assign mem_wr_o     = mem_req_o ? wr_q : 4'h0;
  assign busy_o       = (state_q != ST_IDLE);
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Bench for riscv_mem_arbiter: directed sequences, a grant-rule vector table and a
// randomized run checked against a transaction-level reference model.
module tb_riscv_mem_arbiter;
  localparam int STARVE = 4;
  localparam int TMO    = 8;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        i_rd_i, i_accept_o, i_valid_o, i_error_o;
  logic [31:0] i_pc_i, i_inst_o;
  logic        d_rd_i, d_accept_o, d_ack_o, d_error_o;
  logic [3:0]  d_wr_i, mem_wr_o;
  logic [31:0] d_addr_i, d_data_wr_i, d_data_rd_o;
  logic [10:0] d_req_tag_i, d_resp_tag_o;
  logic        mem_req_o, mem_accept_i, mem_rd_o, mem_ack_i, mem_error_i, busy_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  int n_checks = 0;
  int n_pass   = 0;

  riscv_mem_arbiter #(.STARVE_LIMIT(STARVE), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .i_rd_i(i_rd_i), .i_pc_i(i_pc_i), .i_accept_o(i_accept_o), .i_valid_o(i_valid_o),
    .i_inst_o(i_inst_o), .i_error_o(i_error_o),
    .d_rd_i(d_rd_i), .d_wr_i(d_wr_i), .d_addr_i(d_addr_i), .d_data_wr_i(d_data_wr_i),
    .d_req_tag_i(d_req_tag_i), .d_accept_o(d_accept_o), .d_ack_o(d_ack_o),
    .d_data_rd_o(d_data_rd_o), .d_error_o(d_error_o), .d_resp_tag_o(d_resp_tag_o),
    .mem_req_o(mem_req_o), .mem_accept_i(mem_accept_i), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .mem_error_i(mem_error_i),
    .busy_o(busy_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic idle_inputs();
    i_rd_i = 0; i_pc_i = 0; d_rd_i = 0; d_wr_i = 0; d_addr_i = 0; d_data_wr_i = 0;
    d_req_tag_i = 0; mem_accept_i = 0; mem_ack_i = 0; mem_rdata_i = 0; mem_error_i = 0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    idle_inputs();
    @(posedge clk);
    @(posedge clk);
    #1 rst_i = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       i_rd;
    logic       d_rd;
    logic [3:0] d_wr;
    logic       exp_i_acc;
    logic       exp_d_acc;
  } vec_t;
  vec_t vecs[8];

  // reference model state for the random run
  logic [44:0] exp_q[$];
  int          m_phase, m_wn, m_k, m_starve;
  logic        m_is_d, m_rd;
  logic [3:0]  m_wr;
  logic [31:0] m_addr, m_wdata, last_i, last_d;
  logic [10:0] m_tag;

  initial begin
    byte   order[10];
    string exp_order;
    int    n, lat, hs;
    logic  seen, ack_next, drop_i, drop_d, gi, gd, ipend, dpend;
    logic [44:0] e;

    vecs[0] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 4'h0, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 4'h3, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 4'h0, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 4'hF, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 4'h1, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 4'h8, 1'b0, 1'b1};

    do_reset();
    @(negedge clk);
    chk("rst_busy", busy_o, 0);
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_resp", {i_valid_o, d_ack_o, i_error_o, d_error_o}, 0);
    chk("rst_data", {i_inst_o, d_data_rd_o, d_resp_tag_o}, 0);

    // fetch only, best-case latency
    step();
    i_rd_i = 1; i_pc_i = 32'h100;
    @(negedge clk);
    chk("f_accept", {i_accept_o, d_accept_o}, 2'b10);
    step();
    i_rd_i = 0; mem_accept_i = 1;
    @(negedge clk);
    chk("f_req", {mem_req_o, mem_rd_o, mem_wr_o, busy_o}, 7'b1_1_0000_1);
    chk("f_addr", mem_addr_o, 32'h100);
    step();
    mem_accept_i = 0; mem_ack_i = 1; mem_rdata_i = 32'h13;
    @(negedge clk);
    chk("f_wait", {mem_req_o, i_valid_o}, 0);
    step();
    mem_ack_i = 0; mem_rdata_i = 32'hBAD0BAD0;
    @(negedge clk);
    chk("f_valid", {i_valid_o, i_error_o, busy_o}, 3'b100);
    chk("f_inst", i_inst_o, 32'h13);
    step();
    @(negedge clk);
    chk("f_pulse_1cyc", i_valid_o, 0);
    chk("f_inst_hold", i_inst_o, 32'h13);

    // data write
    step();
    d_wr_i = 4'b0011; d_addr_i = 32'h2000; d_data_wr_i = 32'hDEADBEEF; d_req_tag_i = 11'h155;
    @(negedge clk);
    chk("w_accept", {i_accept_o, d_accept_o}, 2'b01);
    step();
    d_wr_i = 0; mem_accept_i = 1;
    @(negedge clk);
    chk("w_req", {mem_req_o, mem_rd_o, mem_wr_o}, 6'b1_0_0011);
    chk("w_addr", mem_addr_o, 32'h2000);
    chk("w_wdata", mem_wdata_o, 32'hDEADBEEF);
    step();
    mem_accept_i = 0; mem_ack_i = 1; mem_rdata_i = 32'h12345678;
    step();
    mem_ack_i = 0;
    @(negedge clk);
    chk("w_ack", {d_ack_o, d_error_o, i_valid_o}, 3'b100);
    chk("w_tag", d_resp_tag_o, 11'h155);
    chk("w_rdata_pass", d_data_rd_o, 32'h12345678);

    // reset in D_WAIT
    step();
    d_rd_i = 1; d_addr_i = 32'h5000; d_req_tag_i = 11'h33;
    @(negedge clk);
    chk("r_accept", d_accept_o, 1);
    step();
    mem_accept_i = 1;
    step();
    mem_accept_i = 0;
    @(negedge clk);
    chk("r_in_wait", {busy_o, mem_req_o}, 2'b10);
    rst_i = 1;
    #1;
    chk("r_async_busy", busy_o, 0);
    chk("r_async_ctl", {mem_req_o, mem_rd_o, mem_wr_o, i_accept_o, d_accept_o, d_ack_o, i_valid_o}, 0);
    chk("r_async_data", {d_data_rd_o, d_resp_tag_o, mem_addr_o}, 0);
    step();
    rst_i = 0; d_rd_i = 0; mem_ack_i = 1; mem_rdata_i = 32'h77;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("r_no_resp", {d_ack_o, i_valid_o, busy_o}, 0);
      step();
      mem_ack_i = 0;
    end

    // contention and starvation guard
    do_reset();
    i_rd_i = 1; d_rd_i = 1; mem_accept_i = 1;
    n = 0; ack_next = 0;
    for (int c = 0; c < 200 && n < 10; c++) begin
      mem_ack_i = ack_next;
      @(negedge clk);
      if (i_accept_o) begin order[n] = "I"; n++; end
      else if (d_accept_o) begin order[n] = "D"; n++; end
      ack_next = mem_req_o && mem_accept_i;
      step();
    end
    idle_inputs();
    chk("c_grant_count", n, 10);
    exp_order = "DDDDIDDDDI";
    for (int g = 0; g < 10; g++) chk($sformatf("c_grant_%0d", g), order[g], exp_order[g]);

    // backpressure
    do_reset();
    d_rd_i = 1; d_addr_i = 32'h3000; d_req_tag_i = 11'h7;
    @(negedge clk);
    chk("b_accept", d_accept_o, 1);
    hs = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      d_rd_i = 0; mem_accept_i = (c == 5);
      @(negedge clk);
      chk("b_req_stable", mem_req_o, 1);
      chk("b_addr_stable", mem_addr_o, 32'h3000);
      if (mem_req_o && mem_accept_i) hs++;
    end
    step();
    mem_accept_i = 1; mem_ack_i = 1; mem_rdata_i = 32'hA5A5;
    @(negedge clk);
    if (mem_req_o && mem_accept_i) hs++;
    chk("b_one_accept", hs, 1);
    step();
    idle_inputs();
    @(negedge clk);
    chk("b_ack", {d_ack_o, d_resp_tag_o}, {1'b1, 11'h7});

    // timeout
    do_reset();
    d_rd_i = 1; d_addr_i = 32'h4000; d_req_tag_i = 11'h2A;
    @(negedge clk);
    chk("t_accept", d_accept_o, 1);
    step();
    d_rd_i = 0; mem_accept_i = 1; mem_rdata_i = 32'hFFFFFFFF;
    @(negedge clk);
    chk("t_req", mem_req_o, 1);
    step();
    mem_accept_i = 0;
    seen = 0; lat = 0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clk);
      if (d_ack_o) begin
        seen = 1; lat = c;
        chk("t_err", d_error_o, 1);
        chk("t_data_zero", d_data_rd_o, 0);
        chk("t_tag", d_resp_tag_o, 11'h2A);
        chk("t_idle", busy_o, 0);
      end
      step();
    end
    chk("t_resp_seen", seen, 1);
    chk("t_latency", lat, TMO + 1);
    mem_ack_i = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t_stray_ignored", {d_ack_o, i_valid_o, busy_o}, 0);
      step();
      mem_ack_i = 0;
    end

    // grant-rule vectors, each from a freshly reset IDLE
    foreach (vecs[v]) begin
      @(negedge clk);
      rst_i = 1; #1 rst_i = 0;
      i_rd_i = vecs[v].i_rd; d_rd_i = vecs[v].d_rd; d_wr_i = vecs[v].d_wr;
      #1;
      chk($sformatf("v%0d_accept", v), {i_accept_o, d_accept_o}, {vecs[v].exp_i_acc, vecs[v].exp_d_acc});
      chk($sformatf("v%0d_idle", v), {busy_o, mem_req_o}, 0);
      idle_inputs();
    end

    // randomized run against the reference model
    do_reset();
    m_phase = 0; m_wn = 0; m_k = 0; m_starve = 0; last_i = 0; last_d = 0;
    m_is_d = 0; m_rd = 0; m_wr = 0; m_addr = 0; m_wdata = 0; m_tag = 0;
    drop_i = 0; drop_d = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (drop_i) i_rd_i = 0;
      if (drop_d) begin d_rd_i = 0; d_wr_i = 0; end
      drop_i = 0; drop_d = 0;
      if (!i_rd_i && $urandom_range(0, 2) == 0) begin
        i_rd_i = 1; i_pc_i = $urandom & 32'hFFFFFFFC;
      end
      if (!d_rd_i && d_wr_i == 0 && $urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 1) == 1) d_rd_i = 1;
        else d_wr_i = 4'($urandom_range(1, 15));
        d_addr_i = $urandom; d_data_wr_i = $urandom; d_req_tag_i = 11'($urandom_range(0, 2047));
      end
      mem_accept_i = ($urandom_range(0, 2) != 0);
      mem_rdata_i  = $urandom;
      mem_error_i  = ($urandom_range(0, 5) == 0);
      if (m_phase == 2) mem_ack_i = (m_wn == m_k);
      else mem_ack_i = ($urandom_range(0, 7) == 0);

      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e[44]) begin
          chk("rnd_d_ack", {d_ack_o, i_valid_o}, 2'b10);
          chk("rnd_d_data", d_data_rd_o, e[31:0]);
          chk("rnd_d_err", d_error_o, e[43]);
          chk("rnd_d_tag", d_resp_tag_o, e[42:32]);
          last_d = e[31:0];
        end else begin
          chk("rnd_i_valid", {i_valid_o, d_ack_o}, 2'b10);
          chk("rnd_i_inst", i_inst_o, e[31:0]);
          chk("rnd_i_err", i_error_o, e[43]);
          last_i = e[31:0];
        end
      end else begin
        chk("rnd_no_resp", {i_valid_o, d_ack_o}, 0);
        chk("rnd_i_hold", i_inst_o, last_i);
        chk("rnd_d_hold", d_data_rd_o, last_d);
      end
      chk("rnd_busy", busy_o, m_phase != 0);
      chk("rnd_mem_req", mem_req_o, m_phase == 1);
      if (m_phase == 1) begin
        chk("rnd_mem_addr", mem_addr_o, m_addr);
        chk("rnd_mem_rdwr", {mem_rd_o, mem_wr_o}, {m_rd, m_wr});
        if (m_is_d) chk("rnd_mem_wdata", mem_wdata_o, m_wdata);
      end else begin
        chk("rnd_mem_rdwr_off", {mem_rd_o, mem_wr_o}, 0);
      end

      gi = 0; gd = 0;
      ipend = i_rd_i; dpend = d_rd_i || (d_wr_i != 0);
      if (m_phase == 0) begin
        if (ipend && dpend) begin
          if (m_starve >= STARVE) gi = 1; else gd = 1;
        end else begin
          gi = ipend; gd = dpend;
        end
      end
      chk("rnd_accept", {i_accept_o, d_accept_o}, {gi, gd});

      case (m_phase)
        0: begin
          if (gi) begin
            m_is_d = 0; m_addr = i_pc_i; m_rd = 1; m_wr = 0; m_tag = 0;
            m_starve = 0; m_phase = 1; drop_i = 1;
          end else if (gd) begin
            m_is_d = 1; m_addr = d_addr_i; m_rd = d_rd_i; m_wr = d_wr_i;
            m_wdata = d_data_wr_i; m_tag = d_req_tag_i;
            if (ipend && m_starve < STARVE) m_starve++;
            m_phase = 1; drop_d = 1;
          end
        end
        1: if (mem_accept_i) begin
          m_phase = 2; m_wn = 0; m_k = $urandom_range(0, TMO + 2);
        end
        default: begin
          if (mem_ack_i) begin
            exp_q.push_back({m_is_d, mem_error_i, m_tag, mem_rdata_i});
            m_phase = 0;
          end else if (m_wn == TMO - 1) begin
            exp_q.push_back({m_is_d, 1'b1, m_tag, 32'h0});
            m_phase = 0;
          end else begin
            m_wn++;
          end
        end
      endcase
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/riscv_mem_arbiter.md
Name: riscv_mem_arbiter

Overview:
- Shares one downstream memory bus between the core's instruction-fetch port (mem_i_*) and data port (mem_d_*).
- Sits between riscv_core and the single-ported system memory or bus bridge.
- Handles one outstanding transaction at a time.
- Data requests have priority, with a starvation guard for fetches and a response timeout that returns a bus error.

Parameters:
- STARVE_LIMIT, 4: maximum consecutive data grants while a fetch is pending. At this count the next grant goes to fetch.
- TIMEOUT_CYCLES, 255: cycles to wait for mem_ack_i before returning an error response. Must be ≥1 and fit in 8 bits.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- i_rd_i  in  1  fetch request from core; held until i_accept_o
- i_pc_i  in  32  fetch address
- i_accept_o  out  1  fetch request accepted (1-cycle pulse)
- i_valid_o  out  1  fetch response valid (1-cycle pulse)
- i_inst_o  out  32  fetched instruction
- i_error_o  out  1  fetch bus error, qualified by i_valid_o
- d_rd_i  in  1  data read request
- d_wr_i  in  4  data write byte strobes; non-zero means write
- d_addr_i  in  32  data address
- d_data_wr_i  in  32  write data
- d_req_tag_i  in  11  request tag
- d_accept_o  out  1  data request accepted (1-cycle pulse)
- d_ack_o  out  1  data response (1-cycle pulse)
- d_data_rd_o  out  32  read data
- d_error_o  out  1  data bus error, qualified by d_ack_o
- d_resp_tag_o  out  11  tag of the completed request
- mem_req_o  out  1  downstream request valid
- mem_accept_i  in  1  downstream accepted request
- mem_addr_o  out  32  downstream address
- mem_wdata_o  out  32  downstream write data
- mem_rd_o  out  1  downstream read
- mem_wr_o  out  4  downstream byte strobes
- mem_ack_i  in  1  downstream response
- mem_rdata_i  in  32  downstream read data
- mem_error_i  in  1  downstream error, qualified by mem_ack_i
- busy_o  out  1  high in every state except IDLE

Behaviour:
- Reset: rst_i high asynchronously forces state IDLE, clears all outputs and starve_cnt/timeout_cnt to 0, and clears latched fields. An in-flight transaction is abandoned and no response is issued.
- States: IDLE, I_ADDR, I_WAIT, D_ADDR, D_WAIT.
- A data request is pending when d_rd_i=1 or d_wr_i≠0. A fetch request is pending when i_rd_i=1.
- IDLE grant rules:
  - Only one requester pending: it wins.
  - Both pending: D wins unless starve_cnt==STARVE_LIMIT, in which case I wins.
- Grant cycle:
  - The winner's accept_o is high combinationally in that IDLE cycle.
  - Request fields (addr, wdata, strobes, rd, tag) are latched at the clock edge.
  - Next state is I_ADDR or D_ADDR.
  - A fetch grant latches rd=1 and wr=0.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, on a D grant while a fetch is pending.
  - Resets to 0 on any I grant.
  - Unchanged otherwise.
- X_ADDR state:
  - mem_req_o=1 with latched fields driven onto mem_* outputs.
  - On mem_accept_i=1, go to X_WAIT and clear timeout_cnt.
  - Fields stay stable until accepted.
  - mem_req_o=0 and mem_rd_o/mem_wr_o=0 in all other states.
- X_WAIT state:
  - timeout_cnt increments each cycle without mem_ack_i.
  - On mem_ack_i: next cycle pulse i_valid_o (or d_ack_o) with rdata=mem_rdata_i, error=mem_error_i and d_resp_tag_o=latched tag, then go to IDLE.
  - Read data is passed through for writes as well.
- Timeout: when timeout_cnt reaches TIMEOUT_CYCLES with no ack, respond with error=1 and data=0, then go to IDLE. If mem_ack_i and timeout coincide, the ack wins.
- mem_ack_i seen in IDLE or X_ADDR is ignored.
- Response outputs are registered. Data and tag hold their last value between pulses; valid/ack/error pulses are exactly 1 cycle.
- Latency, best case (accept in the cycle after grant, ack the cycle after that): grant at T, mem_req_o at T+1, ack at T+2, response at T+3. The earliest next grant is at T+3.
- A request deasserted before accept is not granted. A request that is granted is always completed.

Test Plan:
- Fetch only: i_rd_i=1, i_pc_i=0x100. Memory accepts immediately and acks 1 cycle later with 0x00000013. Expect i_accept_o pulse at T, mem_addr_o=0x100 with mem_rd_o=1 at T+1, and i_valid_o=1, i_inst_o=0x00000013, i_error_o=0 at T+3.
- Data write: d_wr_i=4'b0011, d_addr_i=0x2000, d_data_wr_i=0xDEADBEEF, tag=0x155. Expect mem_wr_o=0011 and mem_wdata_o=0xDEADBEEF, then d_ack_o with d_resp_tag_o=0x155.
- Contention and starvation: hold i_rd_i and d_rd_i continuously with STARVE_LIMIT=4. Grant order is D,D,D,D,I,D,D,D,D,I.
- Backpressure: hold mem_accept_i=0 for 5 cycles. mem_req_o and mem_addr_o stay stable for all 6 cycles, and exactly one request is accepted.
- Timeout: TIMEOUT_CYCLES=8, never ack a data read. d_ack_o=1 with d_error_o=1 and d_data_rd_o=0, the block returns to IDLE, and a later stray mem_ack_i in IDLE produces no response.
- Reset mid-transaction: assert rst_i during D_WAIT. Outputs are 0 immediately (asynchronously), busy_o=0, and no d_ack_o is issued after reset release.
